// File: rtl/la32r_inst_encoder.sv
// Streaming LA32R instruction encoder: decoded request -> 32-bit word + address, 2-entry output FIFO.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module la32r_inst_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h1C00_0000,
   parameter int          ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [4:0]           in_op,
   input  logic [4:0]           in_rd,
   input  logic [4:0]           in_rj,
   input  logic [4:0]           in_rk,
   input  logic [31:0]          in_imm,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_inst,
   output logic [31:0]          out_addr,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_cnt
);

   typedef enum logic [2:0] {F_3R, F_SHI, F_RI12S, F_RI12U, F_RI20, F_BAD} fmt_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] addr;
   } ent_t;

   fmt_e        w_fmt;
   logic [16:0] w_opc;
   logic [31:0] w_inst;
   logic        w_op_ok;
   logic        w_ok;

   logic        w_full;
   logic        w_acc;
   logic        w_push;
   logic        w_pop;

   ent_t                 r_mem [2];
   logic                 r_wptr;
   logic                 r_rptr;
   logic [1:0]           r_cnt;
   logic [29:0]          r_n;
   logic                 r_err;
   logic [ERR_CNT_W-1:0] r_err_cnt;

   // Operation select -> instruction format and opcode field (right-aligned)
   always_comb begin
      w_fmt = F_BAD;
      w_opc = 17'h0;
      case (in_op)
         5'd0:    begin w_fmt = F_3R;    w_opc = 17'h00020; end
         5'd1:    begin w_fmt = F_3R;    w_opc = 17'h00022; end
         5'd2:    begin w_fmt = F_3R;    w_opc = 17'h00024; end
         5'd3:    begin w_fmt = F_3R;    w_opc = 17'h00025; end
         5'd4:    begin w_fmt = F_3R;    w_opc = 17'h00029; end
         5'd5:    begin w_fmt = F_3R;    w_opc = 17'h0002A; end
         5'd6:    begin w_fmt = F_3R;    w_opc = 17'h0002B; end
         5'd7:    begin w_fmt = F_3R;    w_opc = 17'h0002E; end
         5'd8:    begin w_fmt = F_3R;    w_opc = 17'h0002F; end
         5'd9:    begin w_fmt = F_3R;    w_opc = 17'h00030; end
         5'd10:   begin w_fmt = F_SHI;   w_opc = 17'h00081; end
         5'd11:   begin w_fmt = F_SHI;   w_opc = 17'h00089; end
         5'd12:   begin w_fmt = F_SHI;   w_opc = 17'h00091; end
         5'd13:   begin w_fmt = F_RI12S; w_opc = 17'h00008; end
         5'd14:   begin w_fmt = F_RI12S; w_opc = 17'h00009; end
         5'd15:   begin w_fmt = F_RI12S; w_opc = 17'h0000A; end
         5'd16:   begin w_fmt = F_RI12U; w_opc = 17'h0000D; end
         5'd17:   begin w_fmt = F_RI12U; w_opc = 17'h0000E; end
         5'd18:   begin w_fmt = F_RI12U; w_opc = 17'h0000F; end
         5'd19:   begin w_fmt = F_RI20;  w_opc = 17'h0000A; end
         5'd20:   begin w_fmt = F_RI20;  w_opc = 17'h0000E; end
         default: begin w_fmt = F_BAD;   w_opc = 17'h0;     end
      endcase
   end

   always_comb begin
      w_inst  = 32'h0;
      w_op_ok = 1'b1;
      case (w_fmt)
         F_3R:             w_inst = {w_opc, in_rk, in_rj, in_rd};
         F_SHI:            w_inst = {w_opc, in_imm[4:0], in_rj, in_rd};
         F_RI12S, F_RI12U: w_inst = {w_opc[9:0], in_imm[11:0], in_rj, in_rd};
         F_RI20:           w_inst = {w_opc[6:0], in_imm[31:12], in_rd};
         default:          w_op_ok = 1'b0;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   logic w_imm_ok;

   // Signed 12-bit range means bits [31:11] are a pure sign extension
   always_comb begin
      w_imm_ok = 1'b1;
      case (w_fmt)
         F_SHI:   w_imm_ok = ~|in_imm[31:5];
         F_RI12S: w_imm_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
         F_RI12U: w_imm_ok = ~|in_imm[31:12];
         F_RI20:  w_imm_ok = ~|in_imm[11:0];
         default: w_imm_ok = 1'b1;
      endcase
   end

   assign w_ok = w_op_ok & w_imm_ok;
`else
   assign w_ok = w_op_ok;
`endif

   assign w_full   = (r_cnt == 2'd2);
   assign in_ready = ~w_full & ~clear;
   assign w_acc    = in_valid & in_ready;
   assign w_push   = w_acc & w_ok;
   // clear takes priority over a pop on the same edge
   assign w_pop    = out_valid & out_ready & ~clear;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_cnt  <= 2'd0;
         r_n    <= 30'd0;
      end else if (clear) begin
         r_wptr <= 1'b0;
         r_rptr <= 1'b0;
         r_cnt  <= 2'd0;
         r_n    <= 30'd0;
      end else begin
         if (w_push) begin
            r_wptr <= ~r_wptr;
            r_n    <= r_n + 30'd1;
         end
         if (w_pop)
            r_rptr <= ~r_rptr;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage needs no reset: the head is masked by out_valid
   always_ff @(posedge clk) begin
      if (w_push && !clear) begin
         r_mem[r_wptr].inst <= w_inst;
         r_mem[r_wptr].addr <= BASE_ADDR + {r_n, 2'b00};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_err <= w_acc & ~w_ok;
         if (w_acc && !w_ok && (r_err_cnt != {ERR_CNT_W{1'b1}}))
            r_err_cnt <= r_err_cnt + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign out_valid = (r_cnt != 2'd0);
   assign out_inst  = out_valid ? r_mem[r_rptr].inst : 32'h0;
   assign out_addr  = out_valid ? r_mem[r_rptr].addr : 32'h0;
   assign err       = r_err;
   assign err_cnt   = r_err_cnt;

endmodule
